// File: rtl/request_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : request_encoder
//  Description : 8-to-3 buffered request encoder. This is the inverse of the
//                3-to-8 decoder. Request lines a..h (indices 0..7) are
//                captured into a pending vector while oe = 1. One pending
//                index at a time is offered to the consumer through a
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1  rising-edge clock for all state
//    rst_n    in   1  asynchronous active-low reset
//    oe       in   1  capture enable (1 = sample request lines)
//    a..h     in   1  request lines, a = index 0 ... h = index 7
//    ready    in   1  consumer accepts code (handshake = valid & ready)
//    code     out  3  offered index, meaningful while valid = 1
//    valid    out  1  code is being offered
//    pending  out  8  registered pending-request vector
// ----------------------------------------------------------------------------
//  Configuration
//    ROUND_ROBIN_EN  defined   : round-robin arbitration. A 3-bit pointer
//                                holds the last-served index. The search
//                                starts at pointer + 1.
//                    undefined : fixed priority; the lowest set index wins.
// ============================================================================
module request_encoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       oe,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       h,
    input  logic       ready,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] code_q,  code_d;
    logic [7:0] pending_q, pending_d;

    logic [7:0] w_req;
    logic       w_handshake;
    logic [7:0] w_clear;
    logic [2:0] w_sel_idle;   // choice made from the registered pending vector
    logic [2:0] w_sel_next;   // choice made from the post-handshake vector

    assign w_req       = {h, g, f, e, d, c, b, a};
    assign w_handshake = (state_q == HOLD) && ready;
    assign w_clear     = w_handshake ? (8'd1 << code_q) : 8'd0;

    // The clear is applied first and the new requests are ORed in afterwards.
    // A bit that is served and re-requested in the same cycle stays set.
    assign pending_d = (pending_q & ~w_clear) | (oe ? w_req : 8'd0);

`ifdef ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;

    // Scan ptr+1, ptr+2, ... wrapping 7 -> 0. The pointer index itself is
    // checked last.
    function automatic logic [2:0] f_select(input logic [7:0] vec,
                                            input logic [2:0] ptr);
        logic [2:0] idx;
        logic       found;
        logic [2:0] res;
        res   = 3'd0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && vec[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign ptr_d = w_handshake ? code_q : ptr_q;

    // On a handshake, the index being served becomes the new last-served
    // index. Using it here lets the back-to-back pick see the updated
    // pointer on the same edge.
    assign w_sel_idle = f_select(pending_q, ptr_q);
    assign w_sel_next = f_select(pending_d, code_q);
`else
    // Scan from the top down so that the lowest set index is written last
    // and therefore wins.
    function automatic logic [2:0] f_select(input logic [7:0] vec);
        logic [2:0] res;
        res = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                res = 3'(i);
            end
        end
        return res;
    endfunction

    assign w_sel_idle = f_select(pending_q);
    assign w_sel_next = f_select(pending_d);
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                // The selection uses registered pending. This gives the
                // fixed two-edge request-to-valid latency.
                if (pending_q != 8'd0) begin
                    code_d  = w_sel_idle;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Without ready, code is frozen even if a higher-priority
                // request arrives.
                if (ready) begin
                    if (pending_d != 8'd0) begin
                        code_d = w_sel_next;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= 3'd0;
            pending_q <= 8'd0;
`ifdef ROUND_ROBIN_EN
            ptr_q     <= 3'd7;
`endif
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
`ifdef ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign code    = code_q;
    assign valid   = (state_q == HOLD);
    assign pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_request_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_request_encoder
//  Description : Self-checking bench for request_encoder. Directed scenarios
//                and randomized traffic are compared against a cycle-level
//                behavioural model of the pending set and the offer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_request_encoder;

    logic       clk;
    logic       rst_n;
    logic       oe;
    logic       ready;
    logic [7:0] req;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;

    int n_checks;
    int n_errors;

    request_encoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .oe      (oe),
        .a       (req[0]),
        .b       (req[1]),
        .c       (req[2]),
        .d       (req[3]),
        .e       (req[4]),
        .f       (req[5]),
        .g       (req[6]),
        .h       (req[7]),
        .ready   (ready),
        .code    (code),
        .valid   (valid),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: the pending set and the current offer.
    // ------------------------------------------------------------------
    logic [7:0] m_pend  = 8'd0;
    logic       m_valid = 1'b0;
    logic [2:0] m_code  = 3'd0;
    logic [2:0] m_last  = 3'd7;

    function automatic logic [2:0] pick(input logic [7:0] set, input logic [2:0] last);
        int k;
`ifdef ROUND_ROBIN_EN
        for (k = 1; k <= 8; k++) begin
            if (set[(int'(last) + k) % 8]) return 3'((int'(last) + k) % 8);
        end
`else
        for (k = 0; k < 8; k++) begin
            if (set[k]) return 3'(k + 0 * int'(last));
        end
`endif
        return 3'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] p;
        logic       hs;
        if (!rst_n) begin
            m_pend  <= 8'd0;
            m_valid <= 1'b0;
            m_code  <= 3'd0;
            m_last  <= 3'd7;
        end else begin
            p  = m_pend;
            hs = m_valid && ready;
            if (hs) p[m_code] = 1'b0;
            if (oe) p = p | req;
            if (!m_valid) begin
                if (m_pend != 8'd0) begin
                    m_valid <= 1'b1;
                    m_code  <= pick(m_pend, m_last);
                end
            end else if (hs) begin
                m_last <= m_code;
                if (p != 8'd0) m_code  <= pick(p, m_code);
                else           m_valid <= 1'b0;
            end
            m_pend <= p;
        end
    end

    // ------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; oe = 1'b0; ready = 1'b0; req = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; oe = 1'b0; ready = 1'b0; req = 8'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (pending !== 8'h00) begin n_errors++; $display("FAIL reset_pending: got %h want 00", pending); end
        n_checks++;
        if (valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++;
        if (code !== 3'd0) begin n_errors++; $display("FAIL reset_code: got %0d want 0", code); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        oe = 1'b1; req = 8'h04; ready = 1'b1;
        @(negedge clk);
        req = 8'h00;
        n_checks++;
        if (pending !== 8'h04 || valid !== 1'b0) begin
            n_errors++; $display("FAIL single_edge1: pending=%h valid=%b want 04/0", pending, valid);
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || code !== 3'd2) begin
            n_errors++; $display("FAIL single_edge2: valid=%b code=%0d want 1/2", valid, code);
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            n_errors++; $display("FAIL single_edge3: valid=%b pending=%h want 0/00", valid, pending);
        end
    endtask

    task automatic test_stall();
        do_reset();
        oe = 1'b1; req = 8'h81; ready = 1'b0;
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (valid !== 1'b1 || code !== 3'd0) begin
                n_errors++; $display("FAIL stall_hold[%0d]: valid=%b code=%0d want 1/0", i, valid, code);
            end
            if (i < 4) @(negedge clk);
        end
        ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || code !== 3'd7) begin
            n_errors++; $display("FAIL stall_next: valid=%b code=%0d want 1/7", valid, code);
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0) begin
            n_errors++; $display("FAIL stall_drain: valid=%b want 0", valid);
        end
    endtask

    task automatic test_masking();
        do_reset();
        oe = 1'b0; req = 8'hFF; ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (pending !== 8'h00 || valid !== 1'b0) begin
                n_errors++; $display("FAIL mask[%0d]: pending=%h valid=%b want 00/0", i, pending, valid);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_set_beats_clear();
        do_reset();
        oe = 1'b1; req = 8'h08; ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (valid !== 1'b1 || code !== 3'd3 || pending[3] !== 1'b1) begin
                n_errors++; $display("FAIL set_clear[%0d]: valid=%b code=%0d pending=%h want 1/3/bit3", i, valid, code, pending);
            end
            @(negedge clk);
        end
        req = 8'h00;
    endtask

    task automatic test_rr();
        logic [2:0] exp_seq [4];
`ifdef ROUND_ROBIN_EN
        exp_seq = '{3'd0, 3'd1, 3'd0, 3'd1};
`else
        exp_seq = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
        do_reset();
        oe = 1'b1; req = 8'h03; ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (valid !== 1'b1 || code !== exp_seq[i]) begin
                n_errors++; $display("FAIL arb_seq[%0d]: valid=%b code=%0d want 1/%0d", i, valid, code, exp_seq[i]);
            end
            @(negedge clk);
        end
        req = 8'h00;
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        oe = 1'b1; req = 8'hFF; ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || pending !== 8'hFF) begin
            n_errors++; $display("FAIL midrst_pre: valid=%b pending=%h want 1/FF", valid, pending);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h00 || code !== 3'd0) begin
            n_errors++; $display("FAIL midrst_async: valid=%b pending=%h code=%0d want 0/00/0", valid, pending, code);
        end
        req = 8'h00; oe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        oe = 1'b1; req = 8'h04;
        @(negedge clk);
        req = 8'h00;
        n_checks++;
        if (pending !== 8'h04) begin
            n_errors++; $display("FAIL midrst_recapture: pending=%h want 04", pending);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            oe    = ($urandom_range(0, 3) != 0);
            req   = 8'($urandom & $urandom & $urandom);
            ready = $urandom_range(0, 1) == 1;
            @(negedge clk);
            n_checks++;
            if (pending !== m_pend || valid !== m_valid || (m_valid && code !== m_code)) begin
                n_errors++;
                $display("FAIL random[%0d]: pending=%h valid=%b code=%0d want %h/%b/%0d",
                         i, pending, valid, code, m_pend, m_valid, m_code);
            end
        end
        req = 8'h00; oe = 1'b0; ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; oe = 1'b0; ready = 1'b0; req = 8'd0;
        test_reset();
        test_single();
        test_stall();
        test_masking();
        test_set_beats_clear();
        test_rr();
        test_reset_mid_offer();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/request_encoder.md
REQUEST_ENCODER -- requirements
Module: request_encoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, as in the following port list.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 oe  input  1  capture enable; 1 = sample request lines, 0 = ignore them.
REQ-005 a, b, c, d, e, f, g, h  input  1 each  request lines for indices 0 through 7 (a = 0, h = 7).
REQ-006 code  output  3  encoded index of the offered request; meaningful only while valid = 1.
REQ-007 valid  output  1  code is being offered to the consumer.
REQ-008 ready  input  1  consumer accepts code; a handshake occurs on a rising edge where valid = 1 and ready = 1.
REQ-009 pending  output  8  registered pending-request vector; bit i corresponds to index i.

Function
REQ-010 The block SHALL perform the inverse of the team's 3-to-8 decoder: 8 request lines in, 3-bit index out, with pending requests buffered.
REQ-011 On each edge with oe = 1, pending SHALL become (pending with the served bit cleared) OR {h,g,f,e,d,c,b,a}.
- With oe = 0, the request inputs SHALL be ignored.
- With oe = 0, pending SHALL change only by clearing the served bit.
REQ-012 A request on an index that is already pending SHALL merge into that bit; requests are not counted.
REQ-013 If a bit is served and re-requested in the same cycle, the set SHALL take priority over the clear: the bit stays 1.
REQ-014 The state machine SHALL have two states, IDLE and HOLD.
REQ-015 IDLE -> HOLD: when pending != 0, on the next edge load code with the selected index, set valid = 1 and enter HOLD.
REQ-016 In HOLD with ready = 0, code and valid SHALL hold stable.
REQ-017 In HOLD with ready = 1 (handshake):
- clear pending[code];
- if any other pending bit is set, or any new request is captured that cycle, load the next selected index on the same edge and stay in HOLD (back-to-back, no bubble);
- otherwise set valid = 0 and return to IDLE.
REQ-018 Latency SHALL be fixed:
- a request sampled at edge k appears in pending after edge k;
- with the block in IDLE, valid = 1 and code are presented after edge k+1.
REQ-019 Deasserting oe while in HOLD SHALL NOT abort the offer; the handshake still completes normally.
REQ-020 The default selection SHALL be fixed priority: the lowest set index wins (a highest, h lowest).
REQ-021 code SHALL never change while valid = 1 and ready = 0, even if a higher-priority request arrives.

Reset
REQ-022 While rst_n = 0, the following SHALL take effect immediately, independent of clk:
- pending = 8'h00, valid = 0, code = 3'b000;
- state = IDLE;
- round-robin pointer = 3'd7, if compiled in.
REQ-023 Asserting reset mid-offer SHALL discard the offer and all pending requests.
REQ-024 After rst_n rises, the first capture SHALL occur on the first following clk edge with oe = 1.

Configuration
REQ-025 Macro ROUND_ROBIN_EN selects the arbitration scheme.
- Defined: a 3-bit pointer records the last-served index, updated on each handshake.
- Defined: the search starts at pointer+1 and wraps 7 -> 0; the first set bit found wins.
- Defined: the reset pointer of 7 makes the first search start at index 0.
- Undefined: fixed priority per REQ-020; no pointer register exists.
REQ-026 Interface, latency and handshake behaviour SHALL be identical with and without the macro.

Verification
REQ-027 Single request: reset; oe=1; c=1 for one cycle; ready=1 -> pending=8'h04 after edge 1; valid=1, code=3'd2 after edge 2; valid=0 after edge 3.
REQ-028 Stall: a=1 and h=1 together; ready=0 for 5 cycles -> code=0 held with valid=1 for all 5 cycles; ready=1 -> code=7 on the next edge with no bubble; then valid=0.
REQ-029 Masking: oe=0 with all lines =1 for 4 cycles -> pending=8'h00, valid=0 throughout.
REQ-030 Set beats clear: d held =1 with ready=1 -> code=3 offered every cycle; pending[3] stays 1.
REQ-031 Reset mid-offer: pending=8'hFF, valid=1; pull rst_n low between clock edges -> valid=0 and pending=8'h00 immediately, before the next edge.
REQ-032 ROUND_ROBIN_EN: a and b held =1 with ready=1 -> code alternates 0,1,0,1; without the macro, code=0 every cycle.
